// File: rtl/strb_period_meas.sv
// Purpose: measures the spacing in clk cycles between single-cycle strobes and reports each period. It asserts locked after a run of consistent periods and pulses timeout when strobes stop arriving.
// Latency: period and period_valid are registered and appear 1 cycle after the strobe. Locked updates in the same cycle as period_valid. Timeout appears 1 cycle after the counter reaches TIMEOUT.
// Backpressure: none. The block always accepts strobe_in, and every output is a free-running pulse or level.
// Optional feature: define STRB_PERIOD_AVG_EN to report a smoothed period (avg += (new-avg)>>>2) and to check tolerance against it.
module strb_period_meas #(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, MEAS, TRACK} state_t;

  // LOCK_COUNT is at most 255, so an 8-bit match counter covers the full range
  localparam int MC_W = 8;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [MC_W-1:0]  match_q, match_d;
  logic             vld_q, vld_d;
  logic             lock_q, lock_d;
  logic             to_q, to_d;

  logic signed [CNT_W:0] diff;
  logic        [CNT_W:0] abs_diff;
  logic                  in_tol;
  logic [CNT_W-1:0]      new_ref;
  logic [MC_W-1:0]       match_inc;

`ifdef STRB_PERIOD_AVG_EN
  logic signed [CNT_W+1:0] avg_delta;
`endif

  // Distance between the fresh interval and the reference, one bit wider than the counter so it cannot wrap
  always_comb begin
    diff     = $signed({1'b0, cnt_q}) - $signed({1'b0, ref_q});
    abs_diff = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    in_tol   = (abs_diff <= (CNT_W+1)'(TOL));
    match_inc = (match_q >= MC_W'(LOCK_COUNT)) ? MC_W'(LOCK_COUNT) : match_q + 1'b1;
  end

`ifdef STRB_PERIOD_AVG_EN
  // Move the smoothed reference a quarter of the way toward the new interval; arithmetic shift keeps the sign
  always_comb begin
    avg_delta = $signed({2'b00, cnt_q}) - $signed({2'b00, ref_q});
    new_ref   = CNT_W'($signed({2'b00, ref_q}) + (avg_delta >>> 2));
  end
`else
  // The reference is simply the last raw interval
  always_comb begin
    new_ref = cnt_q;
  end
`endif

  // Next-state logic for the measurement FSM, the interval counter and the lock tracker
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ref_d    = ref_q;
    period_d = period_q;
    match_d  = match_q;
    vld_d    = 1'b0;
    lock_d   = lock_q;
    to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (strobe_in) begin
          cnt_d   = CNT_W'(1);
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (strobe_in) begin
          // The first full interval seeds the reference; the averaged build starts its average here too
          cnt_d    = CNT_W'(1);
          period_d = cnt_q;
          ref_d    = cnt_q;
          vld_d    = 1'b1;
          match_d  = '0;
          state_d  = TRACK;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          to_d    = 1'b1;
          cnt_d   = '0;
          match_d = '0;
          lock_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TRACK: begin
        // A strobe takes priority over a timeout in the same cycle
        if (strobe_in) begin
          cnt_d    = CNT_W'(1);
          period_d = new_ref;
          ref_d    = new_ref;
          vld_d    = 1'b1;
          if (in_tol) begin
            match_d = match_inc;
            lock_d  = (match_inc == MC_W'(LOCK_COUNT));
          end else begin
            match_d = '0;
            lock_d  = 1'b0;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          // Strobe lost: the last reported period is held
          to_d    = 1'b1;
          cnt_d   = '0;
          match_d = '0;
          lock_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      period_q <= '0;
      match_q  <= '0;
      vld_q    <= 1'b0;
      lock_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      period_q <= period_d;
      match_q  <= match_d;
      vld_q    <= vld_d;
      lock_q   <= lock_d;
      to_q     <= to_d;
    end
  end

  assign period       = period_q;
  assign period_valid = vld_q;
  assign locked       = lock_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_strb_period_meas.sv
module tb_strb_period_meas;

  logic        clk;
  logic        rst_n;
  logic        strobe_in;
  logic [15:0] period;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  int n_pass;
  int n_total;

  strb_period_meas #(
    .CNT_W(16),
    .LOCK_COUNT(4),
    .TOL(2),
    .TIMEOUT(1023)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .strobe_in(strobe_in),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int gap;
    int vld;
    int per;
    int lck;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold strobe low for gap-1 cycles, then strobe for one cycle; outputs are sampled 1ns after that edge.
  task automatic send(input int gap, input string name);
    int q;
    q = 0;
    strobe_in = 1'b0;
    for (int i = 1; i < gap; i++) begin
      tick();
      if (period_valid || timeout) q = 1;
    end
    strobe_in = 1'b1;
    tick();
    strobe_in = 1'b0;
    chk({name, "_quiet_gap"}, q, 0);
  endtask

  initial begin
    int cyc;
    int seen_vld;
    n_pass = 0;
    n_total = 0;
    strobe_in = 1'b0;
    rst_n = 1'b0;

    // Gap from the previous strobe, then the expected valid, period and locked values.
    vecs[0]  = '{5,    0, 0,    0};  // first strobe: no measurement yet
    vecs[1]  = '{10,   1, 10,   0};
    vecs[2]  = '{10,   1, 10,   0};
    vecs[3]  = '{10,   1, 10,   0};
    vecs[4]  = '{10,   1, 10,   0};
    vecs[5]  = '{10,   1, 10,   1};  // fourth match: lock
    vecs[6]  = '{10,   1, 10,   1};
    vecs[7]  = '{11,   1, 11,   1};
    vecs[8]  = '{9,    1, 9,    1};  // |9-11| = 2, still in tolerance
    vecs[9]  = '{10,   1, 10,   1};
    vecs[10] = '{14,   1, 14,   0};  // |14-10| = 4: unlock
    vecs[11] = '{14,   1, 14,   0};
    vecs[12] = '{14,   1, 14,   0};
    vecs[13] = '{14,   1, 14,   0};
    vecs[14] = '{14,   1, 14,   1};  // re-lock after 4 matches
    vecs[15] = '{1023, 1, 1023, 0};  // strobe exactly on the timeout cycle
    vecs[16] = '{1,    1, 1,    0};  // back-to-back strobes
    vecs[17] = '{10,   1, 10,   0};
    vecs[18] = '{10,   1, 10,   0};
    vecs[19] = '{10,   1, 10,   0};
    vecs[20] = '{10,   1, 10,   0};
    vecs[21] = '{10,   1, 10,   1};

    // Check the reset state
    repeat (3) tick();
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(period_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout", int'(timeout), 0);
    #3 rst_n = 1'b1;
    tick();

    // Apply the table-driven strobe train
    for (int v = 0; v < 22; v++) begin
      send(vecs[v].gap, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_valid", v), int'(period_valid), vecs[v].vld);
      if (vecs[v].vld != 0) chk($sformatf("vec%0d_period", v), int'(period), vecs[v].per);
      chk($sformatf("vec%0d_locked", v), int'(locked), vecs[v].lck);
      chk($sformatf("vec%0d_timeout", v), int'(timeout), 0);
    end

    // Stop strobing while locked: expect a timeout 1023 cycles after the last strobe
    cyc = 0;
    seen_vld = 0;
    while (timeout !== 1'b1 && cyc < 1100) begin
      tick();
      cyc++;
      if (period_valid) seen_vld = 1;
    end
    chk("to_delay", cyc, 1023);
    chk("to_no_valid", seen_vld, 0);
    chk("to_locked", int'(locked), 0);
    chk("to_period_held", int'(period), 10);
    tick();
    chk("to_one_cycle", int'(timeout), 0);
    send(4, "post_to_first");
    chk("post_to_first_valid", int'(period_valid), 0);
    send(7, "post_to_second");
    chk("post_to_second_valid", int'(period_valid), 1);
    chk("post_to_second_period", int'(period), 7);

    // Assert reset mid-train with counter at 5, then check the outputs before any clock edge
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_period", int'(period), 0);
    chk("arst_valid", int'(period_valid), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_timeout", int'(timeout), 0);
    #2 rst_n = 1'b1;
    tick();
    send(3, "arst_first");
    chk("arst_first_valid", int'(period_valid), 0);
    send(7, "arst_second");
    chk("arst_second_valid", int'(period_valid), 1);
    chk("arst_second_period", int'(period), 7);
    chk("arst_second_locked", int'(locked), 0);
    tick();
    chk("valid_one_cycle", int'(period_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/strb_period_meas.md
Name: strb_period_meas

Overview:
- Receive-side companion to the clock-domain strobe generators. Measures the interval in clk cycles between single-cycle strobes arriving on strobe_in.
- Reports each measured period and declares lock after a run of consistent periods. Flags loss of strobe via timeout.
- Used in the RFID reader datapath to check tag/link-rate strobes and recovered timing pulses before downstream decoders consume them.

Parameters:
- CNT_W, 16, width of the interval counter and the period output.
- LOCK_COUNT, 4, number of consecutive in-tolerance periods required to assert locked; range 1..255.
- TOL, 2, maximum allowed absolute difference in cycles between a new period and the reference period.
- TIMEOUT, 1023, cycle count since the last strobe at which loss is declared; must satisfy 2 <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- strobe_in  input  1  strobe, sampled every cycle; each high cycle counts as one strobe.
- period  output  CNT_W  last measured (or averaged) period in cycles.
- period_valid  output  1  one-cycle pulse; period updated this cycle.
- locked  output  1  level; consistent strobe train detected.
- timeout  output  1  one-cycle pulse; no strobe for TIMEOUT cycles.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, match_cnt=0, reference=0. Outputs period=0, period_valid=0, locked=0, timeout=0.
- Counter:
  - On a strobe cycle, counter<=1.
  - Otherwise, in MEAS or TRACK, counter<=counter+1.
  - Strobes at cycles t and t+N give counter==N at cycle t+N.
- States:
  - IDLE: counter held at 0. First strobe -> MEAS. No period_valid.
  - MEAS: strobe -> period<=counter, reference<=counter, period_valid=1 next cycle, match_cnt<=0 -> TRACK.
  - TRACK, on each strobe:
    - Always: period<=counter, period_valid pulses (latency 1 cycle from strobe).
    - If |counter-reference|<=TOL: match_cnt increments, saturating at LOCK_COUNT.
    - Otherwise: match_cnt<=0 and locked<=0.
    - Reference<=new period in both cases.
    - locked<=1 when match_cnt reaches LOCK_COUNT, registered in the same cycle as that period_valid.
- Timeout: in MEAS or TRACK, counter==TIMEOUT with no strobe that cycle triggers all of:
  - timeout pulses 1 cycle.
  - state->IDLE, counter<=0, match_cnt<=0, locked<=0.
  - period holds its last value.
- Simultaneous strobe and counter==TIMEOUT: strobe wins. The period (=TIMEOUT) is measured and there is no timeout pulse.
- Back-to-back strobes (period 1) are legal and measured as 1.
- Difference computed at CNT_W+1 bits; no wrap. Counter never exceeds TIMEOUT, so no saturation logic is required.
- Reset mid-measurement: immediate return to reset values; the next strobe after release is treated as a first strobe (IDLE).

Optional Feature:
- Macro STRB_PERIOD_AVG_EN.
- Defined:
  - reference and the period output become a smoothed value: avg<=avg+((new-avg)>>>2), signed, CNT_W+2 bits internal, truncated to CNT_W.
  - avg is initialised to the first measured period in MEAS.
  - The tolerance check compares the new period against avg.
  - period_valid timing is unchanged.
- Undefined: raw last period as described above; no averaging logic is synthesised.

Test Plan:
- Strobes every 10 cycles, 6 strobes -> no valid on strobe 1; period=10 with valid one cycle after strobes 2..6; locked rises with the valid of strobe 6 and stays high.
- Locked train, then periods 10,11,9,10 then 14 -> locked stays 1 through the 9; after 14, period=14, locked=0, and re-lock requires 4 more matches.
- Lock achieved, then strobes stop -> timeout pulse exactly 1023 cycles after the last strobe; locked=0, IDLE; the next strobe produces no period_valid.
- Strobe arriving exactly 1023 cycles after the previous one -> period=1023, period_valid=1, timeout=0, state stays TRACK.
- rst_n pulsed low mid-train with counter=5 -> all outputs 0 asynchronously; after release, two strobes 7 cycles apart give the first valid with period=7.
- With STRB_PERIOD_AVG_EN, periods 100 then 108 repeated -> period=100, then 102, 103, 104 ...; the tolerance check runs against avg.
